ads_frame_reader: RTL
=====================

// Module: ads_frame_reader
// PURPOSE
//  Source side of the per-channel sample interface consumed by the peak detect / alarm path.
//  Periodically clocks one frame of 4 back-to-back channel words out of a serial ADC
//  (cs_n/sclk/miso, MSB first). Presents each word as ChN_Data with a 1-cycle ChN_Data_en strobe.
//  One instance per ADC (ads1, ads2); sits between the ADC pins and search_peak_detect.
// PARAMETERS
//  DATAWIDTH      16    bits per channel word; width of ChN_Data
//  CLK_DIV        4     clk cycles per sclk half-period (>=2)
//  SAMPLE_PERIOD  1000  clk cycles from one frame start to the next (>= frame length, else back-to-back)
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  rst          in   1          asynchronous, active-low reset
//  enable       in   1          1 = run periodic frames; 0 = finish current frame, then idle
//  adc_cs_n     out  1          ADC chip select, active low
//  adc_sclk     out  1          ADC serial clock, idle low
//  adc_miso     in   1          ADC serial data, MSB first, ch0 first
//  Ch0_Data     out  DATAWIDTH  last captured ch0 word
//  Ch1_Data     out  DATAWIDTH  last captured ch1 word
//  Ch2_Data     out  DATAWIDTH  last captured ch2 word
//  Ch3_Data     out  DATAWIDTH  last captured ch3 word
//  Ch0_Data_en  out  1          1-cycle strobe: Ch0_Data updated
//  Ch1_Data_en  out  1          1-cycle strobe: Ch1_Data updated
//  Ch2_Data_en  out  1          1-cycle strobe: Ch2_Data updated
//  Ch3_Data_en  out  1          1-cycle strobe: Ch3_Data updated
//  frame_done   out  1          1-cycle strobe, same cycle as Ch3_Data_en
// BEHAVIOUR
//  Reset (rst=0, async): adc_cs_n=1, adc_sclk=0, all ChN_Data=0, all strobes=0.
//  Reset also clears the FSM to IDLE and zeroes the period/bit/div counters. Reset mid-frame
//  aborts immediately; no partial word is ever emitted.
//  Period counter: free-running 0..SAMPLE_PERIOD-1 while enable=1; held at 0 while enable=0.
//  FSM:
//   IDLE  : cs_n=1. Go SETUP when enable=1 and (period cnt==0 or a start is pending).
//           A period tick that lands during a frame sets pending; pending is one deep.
//   SETUP : cs_n=0, sclk=0 for CLK_DIV cycles -> SHIFT.
//   SHIFT : 4*DATAWIDTH sclk periods. Each period: sclk low CLK_DIV cycles, then high CLK_DIV cycles.
//           miso is sampled on the clk edge that ends the high phase (sclk 1->0), shifted in at the LSB.
//           Bit counter 0..4*DATAWIDTH-1 selects the channel (cnt/DATAWIDTH).
//   HOLD  : sclk=0, cs_n=0 for CLK_DIV cycles, then cs_n=1 -> IDLE.
//  Word output: the sample edge of a word's last bit loads the shifted word into ChN_Data and
//   pulses ChN_Data_en. Both become visible in the cycle after that edge (1-cycle latency) and
//   stay high for exactly 1 cycle. At most one ChN_Data_en is high in any cycle.
//  ChN_Data holds its value between strobes. Data never changes in a cycle where the channel's
//   en is low.
//  Frame length = CLK_DIV*(2 + 2*4*DATAWIDTH) clk from cs_n fall to cs_n rise. Defaults: 520 cycles.
//  enable 1->0 mid-frame: the frame completes normally (all 4 strobes and frame_done).
//   Then stay IDLE and clear pending.
//  enable 0->1: the first frame starts on the next cycle (period cnt is 0).
//  SAMPLE_PERIOD < frame length: the next frame starts in the cycle after HOLD ends. Frames are
//   never overlapped and never dropped beyond the one-deep pending.
//  adc_sclk and adc_cs_n come directly from registers (glitch-free).
// TESTING
//  1 Reset: hold rst=0 and toggle miso -> cs_n=1, sclk=0, all data/en=0. Release -> no activity while enable=0.
//  2 Nominal frame with defaults: ADC model drives 0x1234, 0xABCD, 0x8000, 0x7FFF ->
//    strobes in order ch0..ch3, each 1 cycle, with exactly these values; frame_done with Ch3_Data_en;
//    cs_n low for 520 cycles.
//  3 Periodicity: enable=1 for 3 frames -> cs_n falls at intervals of exactly 1000 cycles;
//    sclk half-period = 4 clk; 64 sclk rises per frame.
//  4 enable dropped at bit 20 of a frame -> that frame completes with all 4 strobes; no further cs_n fall.
//  5 rst asserted at bit 40 -> cs_n=1 and sclk=0 async, no Ch2/Ch3 strobe. After release plus
//    enable -> a full clean frame.
//  6 SAMPLE_PERIOD=300 (< 520) -> frames run back to back: cs_n high exactly 1 cycle between frames,
//    every frame delivers all 4 words.

Source files
------------

// File: rtl/ads_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ads_frame_reader
//  Brief    : Periodic serial-ADC frame reader; shifts out 4 channel words per
//             frame and presents each with a 1-cycle data-valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module ads_frame_reader #(
    parameter int DATAWIDTH     = 16,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    input  logic                 adc_miso,
    output logic [DATAWIDTH-1:0] Ch0_Data,
    output logic [DATAWIDTH-1:0] Ch1_Data,
    output logic [DATAWIDTH-1:0] Ch2_Data,
    output logic [DATAWIDTH-1:0] Ch3_Data,
    output logic                 Ch0_Data_en,
    output logic                 Ch1_Data_en,
    output logic                 Ch2_Data_en,
    output logic                 Ch3_Data_en,
    output logic                 frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WB_W  = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] C_PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [WB_W-1:0]  C_WB_LAST  = WB_W'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PER_W-1:0]       period_q;
    logic [DIV_W-1:0]       div_q;
    logic                   phase_q;
    logic [WB_W-1:0]        wbit_q;
    logic [1:0]             ch_q;
    logic [DATAWIDTH-1:0]   shift_q;
    logic                   pend_q;
    logic                   cs_n_q;
    logic                   sclk_q;
    logic [DATAWIDTH-1:0]   data_q [4];
    logic [3:0]             en_q;
    logic                   done_q;

    logic                   w_tick;
    logic [DATAWIDTH-1:0]   w_word;

    assign w_tick = enable && (period_q == '0);
    assign w_word = {shift_q[DATAWIDTH-2:0], adc_miso};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
        end else if (!enable) begin
            period_q <= '0;
        end else if (period_q == C_PER_LAST) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            wbit_q  <= '0;
            ch_q    <= '0;
            shift_q <= '0;
            pend_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            en_q    <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            en_q   <= '0;
            done_q <= 1'b0;

            // A period tick that arrives mid-frame is remembered (one deep)
            if (!enable) begin
                pend_q <= 1'b0;
            end else if (w_tick && (state_q != S_IDLE)) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    if (enable && (w_tick || pend_q)) begin
                        state_q <= S_SETUP;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end

                S_SETUP: begin
                    if (div_q == C_DIV_LAST) begin
                        state_q <= S_SHIFT;
                        div_q   <= '0;
                        phase_q <= 1'b0;
                        wbit_q  <= '0;
                        ch_q    <= '0;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (div_q != C_DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                            sclk_q  <= 1'b1;
                        end else begin
                            // End of high phase: sclk falls and miso is captured
                            phase_q <= 1'b0;
                            sclk_q  <= 1'b0;
                            shift_q <= w_word;
                            if (wbit_q == C_WB_LAST) begin
                                wbit_q       <= '0;
                                data_q[ch_q] <= w_word;
                                en_q[ch_q]   <= 1'b1;
                                ch_q         <= ch_q + 2'd1;
                                if (ch_q == 2'd3) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_HOLD;
                                end
                            end else begin
                                wbit_q <= wbit_q + WB_W'(1);
                            end
                        end
                    end
                end

                S_HOLD: begin
                    sclk_q <= 1'b0;
                    if (div_q == C_DIV_LAST) begin
                        div_q   <= '0;
                        cs_n_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_cs_n    = cs_n_q;
    assign adc_sclk    = sclk_q;
    assign Ch0_Data    = data_q[0];
    assign Ch1_Data    = data_q[1];
    assign Ch2_Data    = data_q[2];
    assign Ch3_Data    = data_q[3];
    assign Ch0_Data_en = en_q[0];
    assign Ch1_Data_en = en_q[1];
    assign Ch2_Data_en = en_q[2];
    assign Ch3_Data_en = en_q[3];
    assign frame_done  = done_q;

endmodule
`default_nettype wire
